// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    localparam int unsigned NUM_BEATS = 4;
    localparam int unsigned PHASE_W   = $clog2(NUM_BEATS);
    localparam int unsigned SEL_W     = 4;

    // Bit positions inside the final beat that carry mode and carry-in.
    localparam int unsigned MODE_BIT  = 0;
    localparam int unsigned CIN_BIT   = 1;

    // One state per beat; the encoding is exported on the phase debug port.
    typedef enum logic [PHASE_W-1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_SEL  = 2'd2,
        S_MODE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_rise_detect.sv
// Registers the synchronized strobe and produces an enable-gated rising-edge pulse.
module rise_detect (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic din,
    output logic pulse
);

    logic strobe_q;

    // Previous strobe level tracks every cycle so an edge seen while ena is low is consumed.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= din;
        end
    end

    assign pulse = din & ~strobe_q & ena;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Assembles A, B, S, M and Cn over four strobe beats and commits them atomically.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 strobe_sync,
    input  logic [WIDTH-1:0]     data_sync,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [SEL_W-1:0]     alu_sel,
    output logic                 alu_m,
    output logic                 alu_cin,
    output logic                 start,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [PHASE_W-1:0]   phase
);

    // Parameter sanity checks at elaboration.
    if (WIDTH < SEL_W) begin : g_width_chk
        $error("alu_operand_sequencer: WIDTH must be >= 4");
    end
    if ((TIMEOUT < 2) || (TIMEOUT > ((1 << TIMEOUT_W) - 1))) begin : g_timeout_chk
        $error("alu_operand_sequencer: TIMEOUT out of range for TIMEOUT_W");
    end

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

    seq_state_t             state_q,      state_d;
    logic [TIMEOUT_W-1:0]   cnt_q,        cnt_d;
    logic [WIDTH-1:0]       shadow_a_q,   shadow_a_d;
    logic [WIDTH-1:0]       shadow_b_q,   shadow_b_d;
    logic [SEL_W-1:0]       shadow_sel_q, shadow_sel_d;
    logic [WIDTH-1:0]       op_a_q,       op_a_d;
    logic [WIDTH-1:0]       op_b_q,       op_b_d;
    logic [SEL_W-1:0]       sel_q,        sel_d;
    logic                   m_q,          m_d;
    logic                   cin_q,        cin_d;
    logic                   start_q,      start_d;
    logic                   err_q,        err_d;

    logic                   beat;
    logic                   timeout_hit;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .din   (strobe_sync),
        .pulse (beat)
    );

    assign timeout_hit = (cnt_q == CNT_LAST);

    // State, timeout counter, shadow and committed registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_A;
            cnt_q        <= '0;
            shadow_a_q   <= '0;
            shadow_b_q   <= '0;
            shadow_sel_q <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sel_q        <= '0;
            m_q          <= 1'b0;
            cin_q        <= 1'b0;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shadow_a_q   <= shadow_a_d;
            shadow_b_q   <= shadow_b_d;
            shadow_sel_q <= shadow_sel_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            sel_q        <= sel_d;
            m_q          <= m_d;
            cin_q        <= cin_d;
            start_q      <= start_d;
            err_q        <= err_d;
        end
    end

    // Next-state: beat loading and commit take priority over the inter-beat timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shadow_a_d   = shadow_a_q;
        shadow_b_d   = shadow_b_q;
        shadow_sel_d = shadow_sel_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        sel_d        = sel_q;
        m_d          = m_q;
        cin_d        = cin_q;
        start_d      = 1'b0;
        err_d        = err_q;

        if (ena) begin
            if (beat) begin
                cnt_d = '0;
                unique case (state_q)
                    S_A: begin
                        shadow_a_d = data_sync;
                        err_d      = 1'b0;
                        state_d    = S_B;
                    end
                    S_B: begin
                        shadow_b_d = data_sync;
                        state_d    = S_SEL;
                    end
                    S_SEL: begin
                        shadow_sel_d = data_sync[SEL_W-1:0];
                        state_d      = S_MODE;
                    end
                    S_MODE: begin
                        op_a_d  = shadow_a_q;
                        op_b_d  = shadow_b_q;
                        sel_d   = shadow_sel_q;
                        m_d     = data_sync[MODE_BIT];
                        cin_d   = data_sync[CIN_BIT];
                        start_d = 1'b1;
                        state_d = S_A;
                    end
                    default: begin
                        state_d = S_A;
                    end
                endcase
            end else if (state_q == S_A) begin
                cnt_d = '0;
            end else if (timeout_hit) begin
                // Abandon the partial sequence; committed outputs stay as they were.
                state_d      = S_A;
                cnt_d        = '0;
                err_d        = 1'b1;
                shadow_a_d   = '0;
                shadow_b_d   = '0;
                shadow_sel_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign alu_sel     = sel_q;
    assign alu_m       = m_q;
    assign alu_cin     = cin_q;
    assign start       = start_q;
    assign timeout_err = err_q;
    assign phase       = state_q;
    assign busy        = (state_q != S_A);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed plus randomized bench for alu_operand_sequencer against a beat-queue model.
module tb_alu_operand_sequencer;

    localparam int unsigned WIDTH     = 4;
    localparam int unsigned TIMEOUT_W = 8;
    localparam int unsigned TIMEOUT   = 200;

    logic             clk;
    logic             rstb;
    logic             ena;
    logic             strobe_sync;
    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       alu_sel;
    logic             alu_m;
    logic             alu_cin;
    logic             start;
    logic             busy;
    logic             timeout_err;
    logic [1:0]       phase;

    int tests = 0;
    int fails = 0;

    alu_operand_sequencer #(
        .WIDTH     (WIDTH),
        .TIMEOUT_W (TIMEOUT_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .strobe_sync (strobe_sync),
        .data_sync   (data_sync),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_sel     (alu_sel),
        .alu_m       (alu_m),
        .alu_cin     (alu_cin),
        .start       (start),
        .busy        (busy),
        .timeout_err (timeout_err),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of beats gathered so far plus an idle-edge count.
    logic [WIDTH-1:0] mq[$];
    int               m_idle;
    bit               m_prev_s;
    bit               m_err;
    bit               m_start;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [3:0]       m_sel;
    bit               m_m;
    bit               m_cin;

    function automatic void model_reset();
        mq.delete();
        m_idle   = 0;
        m_prev_s = 1'b0;
        m_err    = 1'b0;
        m_start  = 1'b0;
        m_a      = '0;
        m_b      = '0;
        m_sel    = '0;
        m_m      = 1'b0;
        m_cin    = 1'b0;
    endfunction

    function automatic void model_edge(input bit s, input bit en, input logic [WIDTH-1:0] d);
        bit               is_beat;
        logic [WIDTH-1:0] third;
        is_beat  = s && !m_prev_s && en;
        m_prev_s = s;
        m_start  = 1'b0;
        if (!en) return;
        if (is_beat) begin
            m_idle = 0;
            if (mq.size() == 0) m_err = 1'b0;
            if (mq.size() == 3) begin
                third   = mq[2];
                m_a     = mq[0];
                m_b     = mq[1];
                m_sel   = third[3:0];
                m_m     = d[0];
                m_cin   = d[1];
                m_start = 1'b1;
                mq.delete();
            end else begin
                mq.push_back(d);
            end
        end else if (mq.size() != 0) begin
            m_idle++;
            if (m_idle == int'(TIMEOUT)) begin
                mq.delete();
                m_idle = 0;
                m_err  = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("phase",       32'(phase),       32'(mq.size()));
        chk("busy",        32'(busy),        32'(mq.size() != 0));
        chk("op_a",        32'(op_a),        32'(m_a));
        chk("op_b",        32'(op_b),        32'(m_b));
        chk("alu_sel",     32'(alu_sel),     32'(m_sel));
        chk("alu_m",       32'(alu_m),       32'(m_m));
        chk("alu_cin",     32'(alu_cin),     32'(m_cin));
        chk("start",       32'(start),       32'(m_start));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
    endtask

    // Drive inputs, advance one clock, update the model, then sample outputs.
    task automatic cycle(input bit s, input bit en, input logic [WIDTH-1:0] d);
        strobe_sync = s;
        ena         = en;
        data_sync   = d;
        @(posedge clk);
        model_edge(s, en, d);
        #1;
        check_all();
    endtask

    task automatic beat(input logic [WIDTH-1:0] d);
        cycle(1'b1, 1'b1, d);
        cycle(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, WIDTH'($urandom));
    endtask

    int kind;
    int n;

    initial begin
        rstb        = 1'b0;
        ena         = 1'b0;
        strobe_sync = 1'b0;
        data_sync   = '0;
        model_reset();

        // Reset state
        #12;
        check_all();
        chk("reset_phase", 32'(phase), 32'd0);
        rstb = 1'b1;

        // Normal load: 3,5,6,2 -> A=3 B=5 S=6 M=0 Cn=1
        beat(WIDTH'(3));
        beat(WIDTH'(5));
        beat(WIDTH'(6));
        cycle(1'b1, 1'b1, WIDTH'(2));
        chk("load_start",  32'(start),   32'd1);
        chk("load_busy",   32'(busy),    32'd0);
        chk("load_a",      32'(op_a),    32'd3);
        chk("load_b",      32'(op_b),    32'd5);
        chk("load_sel",    32'(alu_sel), 32'd6);
        chk("load_m",      32'(alu_m),   32'd0);
        chk("load_cin",    32'(alu_cin), 32'd1);
        cycle(1'b0, 1'b1, '0);
        chk("start_one_cycle", 32'(start), 32'd0);

        // Atomic commit: partial sequence must not disturb committed values
        beat(WIDTH'(4'hA));
        beat(WIDTH'(4'hB));
        beat(WIDTH'(4'hC));
        idle(50);
        chk("atomic_a",   32'(op_a),    32'd3);
        chk("atomic_b",   32'(op_b),    32'd5);
        chk("atomic_sel", 32'(alu_sel), 32'd6);
        idle(160);
        chk("atomic_timeout_err", 32'(timeout_err), 32'd1);

        // Timeout: exactly TIMEOUT idle edges after the last beat
        beat(WIDTH'(1));
        beat(WIDTH'(2));
        idle(TIMEOUT - 2);
        chk("pre_timeout_phase", 32'(phase), 32'd2);
        cycle(1'b0, 1'b1, '0);
        chk("timeout_phase", 32'(phase),       32'd0);
        chk("timeout_err",   32'(timeout_err), 32'd1);
        chk("timeout_keep_a", 32'(op_a),       32'd3);
        beat(WIDTH'(7));
        chk("clear_err",   32'(timeout_err), 32'd0);
        chk("clear_phase", 32'(phase),       32'd1);
        beat(WIDTH'(8));
        beat(WIDTH'(9));
        cycle(1'b1, 1'b1, WIDTH'(1));
        chk("second_commit_a", 32'(op_a), 32'd7);
        cycle(1'b0, 1'b1, '0);

        // Beat and timeout on the same edge: beat wins
        beat(WIDTH'(1));
        beat(WIDTH'(2));
        idle(TIMEOUT - 2);
        cycle(1'b1, 1'b1, WIDTH'(3));
        chk("collide_phase", 32'(phase),       32'd3);
        chk("collide_err",   32'(timeout_err), 32'd0);
        cycle(1'b0, 1'b1, '0);
        beat(WIDTH'(3));

        // ena gating: edge while ena low is dropped, counter frozen
        beat(WIDTH'(4));
        cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 250; i++) cycle(1'b1, 1'b0, WIDTH'(5));
        chk("ena_low_phase", 32'(phase), 32'd1);
        chk("ena_low_start", 32'(start), 32'd0);
        cycle(1'b1, 1'b1, WIDTH'(5));
        chk("ena_return_phase", 32'(phase), 32'd1);
        idle(TIMEOUT - 3);
        chk("frozen_cnt_phase", 32'(phase), 32'd1);
        cycle(1'b0, 1'b1, '0);
        chk("frozen_cnt_timeout", 32'(timeout_err), 32'd1);

        // Async reset mid-sequence in S_SEL
        beat(WIDTH'(5));
        beat(WIDTH'(6));
        chk("pre_reset_phase", 32'(phase), 32'd2);
        #3;
        rstb = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_reset_phase", 32'(phase), 32'd0);
        chk("async_reset_a",     32'(op_a),  32'd0);
        #1;
        rstb = 1'b1;
        beat(WIDTH'(9));
        beat(WIDTH'(8));
        beat(WIDTH'(7));
        cycle(1'b1, 1'b1, WIDTH'(3));
        chk("post_reset_a",   32'(op_a),    32'd9);
        chk("post_reset_b",   32'(op_b),    32'd8);
        chk("post_reset_sel", 32'(alu_sel), 32'd7);
        chk("post_reset_m",   32'(alu_m),   32'd1);
        chk("post_reset_cin", 32'(alu_cin), 32'd1);
        cycle(1'b0, 1'b1, '0);

        // Randomized traffic against the model
        for (int ep = 0; ep < 60; ep++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                for (int i = 0; i < 24; i++)
                    cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), WIDTH'($urandom));
            end else if (kind < 8) begin
                n = int'($urandom_range(TIMEOUT - 5, TIMEOUT + 5));
                idle(n);
            end else begin
                for (int i = 0; i < 12; i++)
                    cycle(1'($urandom_range(0, 1)), 1'b0, WIDTH'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
